// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH     = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  // Wide enough for the largest legal TIMEOUT_CYCLES (65535).
  localparam int unsigned TIMEOUT_CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// APB4 master bridge: turns a valid/ready command into one APB transfer and
// returns a single-cycle response pulse.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that
// see PREADY=0 for TIMEOUT_CYCLES cycles (error response with zero data).
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  // command side
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  // response side
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  // APB4 master
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = TIMEOUT_CNT_WIDTH;

  // Elaboration-time sanity check on the configuration.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) || ((DATA_WIDTH % 8) != 0)) begin : g_param_check
    $error("apb_master_bridge: illegal DATA_WIDTH or TIMEOUT_CYCLES");
  end

  apb_state_e state_q;
  apb_state_e state_d;
  logic       accept_c;
  logic       done_c;
  logic       timeout_c;
  logic       psel_d;
  logic       penable_d;
  logic       ready_d;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Count stalled ACCESS cycles; restart for every new transfer in SETUP.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == ST_ACCESS) && !PREADY) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Fires on the stalled cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout_c = (state_q == ST_ACCESS) && !PREADY &&
                     (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; PREADY wins over a coincident timeout.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept_c = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase outputs decoded from the upcoming state so they can be registered.
  always_comb begin
    psel_d    = 1'b0;
    penable_d = 1'b0;
    ready_d   = 1'b0;
    case (state_d)
      ST_IDLE: begin
        ready_d = 1'b1;
      end
      ST_SETUP: begin
        psel_d = 1'b1;
      end
      ST_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // Registered phase outputs; reset lands in IDLE, ready to accept.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      req_ready_o <= 1'b1;
    end else begin
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      req_ready_o <= ready_d;
    end
  end

  // Capture the command payload on acceptance; held through SETUP and ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (accept_c) begin
      PADDR  <= req_addr_i;
      PWRITE <= req_write_i;
      PWDATA <= req_wdata_i;
      PSTRB  <= req_write_i ? req_strb_i : STRB_WIDTH'(0);
    end
  end

  // Response pulse; data and error hold their last values between pulses.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= done_c | timeout_c;
      if (done_c) begin
        rsp_rdata_o <= PWRITE ? DATA_WIDTH'(0) : PRDATA;
        rsp_err_o   <= PSLVERR;
      end else if (timeout_c) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases plus randomized
// back-to-back transfers against a rule-based reference model.
module tb_apb_master_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_write_i;
  logic [DW-1:0] req_wdata_i;
  logic [SW-1:0] req_strb_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  int            passed = 0;
  int            total  = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] last_rdata;
  logic          last_err;

  apb_master_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i),
    .req_strb_i (req_strb_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next_edge();
    @(posedge PCLK);
    #1;
  endtask

  // PENABLE must never be high while PSEL is low.
  always @(negedge PCLK) begin
    if (mon_en) check("penable_without_psel", 64'(PENABLE & ~PSEL), 64'd0);
  end

  // One complete transfer, starting just after an edge with the bridge in IDLE
  // and ending in the cycle where the response pulse is visible.
  task automatic run_xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input int waits,
                          input logic [DW-1:0] rdata, input logic slverr);
    logic [DW-1:0] exp_rdata;
    logic [SW-1:0] exp_strb;
    exp_rdata = wr ? '0 : rdata;
    exp_strb  = wr ? strb : '0;

    check("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wdata;
    req_strb_i  = strb;
    PREADY      = 1'b0;
    next_edge();
    // SETUP: junk on the request side must be ignored.
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_write_i = ~wr;
    req_strb_i  = SW'($urandom);
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_ready", req_ready_o, 0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, wdata);
    check("setup_pstrb", PSTRB, exp_strb);
    check("setup_rsp_valid", rsp_valid_o, 0);
    check("held_rsp_rdata", rsp_rdata_o, last_rdata);
    check("held_rsp_err", rsp_err_o, last_err);
    next_edge();
    for (int w = 0; w < waits; w++) begin
      PREADY = 1'b0;
      check("wait_psel", PSEL, 1);
      check("wait_penable", PENABLE, 1);
      check("wait_paddr", PADDR, addr);
      check("wait_pwdata", PWDATA, wdata);
      check("wait_pstrb", PSTRB, exp_strb);
      check("wait_rsp_valid", rsp_valid_o, 0);
      next_edge();
    end
    check("access_psel", PSEL, 1);
    check("access_penable", PENABLE, 1);
    check("access_pwrite", PWRITE, wr);
    check("access_rsp_valid", rsp_valid_o, 0);
    req_valid_i = 1'b0;
    PREADY      = 1'b1;
    PRDATA      = rdata;
    PSLVERR     = slverr;
    next_edge();
    PREADY  = 1'b0;
    PRDATA  = $urandom;
    PSLVERR = 1'($urandom);
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_rdata", rsp_rdata_o, exp_rdata);
    check("rsp_err", rsp_err_o, slverr);
    check("rsp_psel", PSEL, 0);
    check("rsp_penable", PENABLE, 0);
    last_rdata = exp_rdata;
    last_err   = slverr;
  endtask

  initial begin
    int n;
    PRESETn     = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    req_strb_i  = '0;
    PREADY      = 1'b0;
    PRDATA      = '0;
    PSLVERR     = 1'b0;
    last_rdata  = '0;
    last_err    = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pstrb", PSTRB, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_ready", req_ready_o, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    mon_en  = 1'b1;
    next_edge();

    // Zero-wait write, then a 4-wait read, then an erroring write.
    run_xfer(32'h100, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'hCAFEF00D, 1'b0);
    run_xfer(32'h204, 1'b0, 32'h55AA55AA, 4'hF, 4, 32'h12345678, 1'b0);
    run_xfer(32'h308, 1'b1, 32'h0BADF00D, 4'h3, 0, 32'h0, 1'b1);
    // Accepted in the same cycle as the error pulse.
    run_xfer(32'h40C, 1'b0, 32'h0, 4'hA, 1, 32'hA5A5A5A5, 1'b1);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 20; i++) begin
      run_xfer(AW'($urandom), 1'($urandom), DW'($urandom), SW'($urandom),
               int'($urandom_range(0, 3)), DW'($urandom), 1'($urandom));
    end
    next_edge();
    check("idle_rsp_valid", rsp_valid_o, 0);
    check("idle_rsp_rdata_held", rsp_rdata_o, last_rdata);
    check("idle_rsp_err_held", rsp_err_o, last_err);
    check("idle_psel", PSEL, 0);

    // Slave stuck with PREADY low.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h500;
    req_write_i = 1'b0;
    next_edge();
    req_valid_i = 1'b0;
    next_edge();
    PREADY = 1'b0;
    n = 0;
`ifdef APB_MASTER_TIMEOUT_EN
    while ((PSEL === 1'b1) && (n < 200)) begin
      next_edge();
      n++;
    end
    check("timeout_access_cycles", 64'(n), 64'(TO));
    check("timeout_rsp_valid", rsp_valid_o, 1);
    check("timeout_rsp_err", rsp_err_o, 1);
    check("timeout_rsp_rdata", rsp_rdata_o, 0);
    last_rdata = '0;
    last_err   = 1'b1;
`else
    while ((PSEL === 1'b1) && (n < 110)) begin
      next_edge();
      n++;
    end
    check("stuck_access_cycles", 64'(n), 64'd110);
    check("stuck_penable", PENABLE, 1);
    check("stuck_rsp_valid", rsp_valid_o, 0);
    PREADY  = 1'b1;
    PRDATA  = 32'h600DCAFE;
    PSLVERR = 1'b0;
    next_edge();
    PREADY = 1'b0;
    check("stuck_rsp_valid_end", rsp_valid_o, 1);
    check("stuck_rsp_rdata", rsp_rdata_o, 32'h600DCAFE);
    last_rdata = 32'h600DCAFE;
    last_err   = 1'b0;
`endif
    next_edge();

    // Reset pulse in the middle of an ACCESS phase.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h700;
    req_write_i = 1'b1;
    req_wdata_i = 32'h11223344;
    req_strb_i  = 4'hF;
    next_edge();
    req_valid_i = 1'b0;
    next_edge();
    check("pre_reset_penable", PENABLE, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("async_rst_psel", PSEL, 0);
    check("async_rst_penable", PENABLE, 0);
    check("async_rst_paddr", PADDR, 0);
    check("async_rst_ready", req_ready_o, 1);
    PREADY = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    last_rdata = '0;
    last_err   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      next_edge();
      check("post_rst_rsp_valid", rsp_valid_o, 0);
      check("post_rst_ready", req_ready_o, 1);
      check("post_rst_psel", PSEL, 0);
    end
    PREADY = 1'b0;

    // Normal operation resumes after reset.
    run_xfer(32'h804, 1'b0, 32'h0, 4'hF, 2, 32'h87654321, 1'b0);
    next_edge();
    check("final_rsp_valid", rsp_valid_o, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net against a hung bench.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles before abort (1..65535).
REQ-004 SHALL have port PCLK  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port PRESETn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid_i in 1 and req_ready_o out 1 for the command handshake.
REQ-007 SHALL have ports req_addr_i in ADDR_WIDTH, req_write_i in 1, req_wdata_i in DATA_WIDTH, req_strb_i in DATA_WIDTH/8 for the command payload.
REQ-008 SHALL have ports rsp_valid_o out 1 (one-cycle pulse), rsp_rdata_o out DATA_WIDTH, rsp_err_o out 1 for the response.
REQ-009 SHALL have APB4 master ports PADDR out ADDR_WIDTH, PSEL out 1, PENABLE out 1, PWRITE out 1, PWDATA out DATA_WIDTH, PSTRB out DATA_WIDTH/8, PREADY in 1, PRDATA in DATA_WIDTH, PSLVERR in 1.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-011 SHALL drive req_ready_o=1 only in IDLE; a command is accepted when req_valid_i and req_ready_o are both 1 at a PCLK edge.
REQ-012 SHALL register PADDR, PWRITE, PWDATA, PSTRB on acceptance and hold them stable through SETUP and ACCESS.
REQ-013 SHALL drive PSTRB to all-zero for read commands regardless of req_strb_i.
REQ-014 SHALL transition IDLE->SETUP on acceptance; SETUP: PSEL=1, PENABLE=0, always exactly one cycle, then ACCESS.
REQ-015 SHALL in ACCESS drive PSEL=1, PENABLE=1 and stay until PREADY=1 sampled at a PCLK edge.
REQ-016 SHALL on the PREADY=1 edge return to IDLE, and in the following cycle assert rsp_valid_o for exactly one cycle with rsp_err_o=PSLVERR and rsp_rdata_o=PRDATA for reads or 0 for writes, both sampled at that edge.
REQ-017 SHALL hold rsp_rdata_o and rsp_err_o at their last values when rsp_valid_o=0.
REQ-018 SHALL give a zero-wait-state transfer 3 cycles from acceptance to rsp_valid_o; the next acceptance can occur in the rsp_valid_o cycle (back-to-back period 3 cycles).
REQ-019 SHALL drive PSEL=0, PENABLE=0 in IDLE; PENABLE SHALL never be 1 while PSEL=0.
REQ-020 SHALL ignore req_valid_i outside IDLE; the requester holds payload until accepted.

Reset
REQ-021 SHALL on PRESETn=0, asynchronously: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, timeout counter=0.
REQ-022 SHALL on reset mid-transfer abandon the transfer and generate no response after reset release.

Configuration
REQ-023 SHALL, with APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles with PREADY=0; when the count reaches TIMEOUT_CYCLES it SHALL return to IDLE and respond next cycle with rsp_err_o=1, rsp_rdata_o=0; the counter clears on each SETUP.
REQ-024 SHALL, without APB_MASTER_TIMEOUT_EN, omit the counter and wait in ACCESS indefinitely; TIMEOUT_CYCLES is unused.
REQ-025 SHALL give PREADY=1 priority over timeout when both occur in the same cycle.

Structure
REQ-026 SHALL place the FSM state enum and default-width constants in shared package apb_pkg.
REQ-027 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-028 Write addr 0x100, wdata 0xDEADBEEF, strb 0xF, PREADY tied 1 -> SETUP then ACCESS with PSTRB=0xF, rsp_valid_o 3 cycles after acceptance, rsp_err_o=0, rsp_rdata_o=0.
REQ-029 Read addr 0x204, slave holds PREADY=0 for 4 ACCESS cycles, PRDATA=0x12345678 -> PSTRB=0, signals stable 4 cycles, rsp_rdata_o=0x12345678 one cycle after PREADY edge.
REQ-030 Write with PSLVERR=1 at PREADY -> rsp_err_o=1 for one pulse, next command accepted in that cycle.
REQ-031 APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY stuck 0 -> PSEL drops after 8 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0; without the macro PSEL stays 1 for 100+ cycles.
REQ-032 PRESETn pulsed low during ACCESS -> PSEL/PENABLE 0 immediately, no rsp_valid_o, req_ready_o=1 after release.
